// File: rtl/mem_ram_ws.sv
// -----------------------------------------------------------------------------
// mem_ram_ws
//
// Single-port word RAM with a programmable number of wait states. Each access
// runs IDLE -> BUSY -> ACK. The request is captured on the edge that accepts
// it. The array is accessed once the wait counter has run down. rdy pulses for
// the single ACK cycle.
//
// Parameters
//   AW      address width; the depth is 2**AW words
//   DW      data word width
//   WAIT    number of wait states, 0..15
//   WP_BASE lowest write-protected address. It is only used when
//           MEM_RAM_WP_EN is defined.
//
// Ports
//   clk     clock; all state changes on the rising edge
//   rst_n   asynchronous active-low reset. It clears the control state and
//           dout, but leaves the array contents alone.
//   sel     access request, sampled only in IDLE
//   wr_n    0 = write, 1 = read; sampled together with sel
//   a       word address
//   din     write data
//   dout    registered read data; it changes only when a read completes
//   rdy     one-cycle completion pulse
//   wp_err  pulses with rdy when a write hits the protected region
//
// Build option
//   MEM_RAM_WP_EN  When this macro is defined, writes to addresses >= WP_BASE
//                  are dropped and flagged on wp_err. When it is undefined,
//                  every write lands and wp_err is tied low.
// -----------------------------------------------------------------------------
module mem_ram_ws #(
   parameter int            AW      = 8,
   parameter int            DW      = 8,
   parameter int            WAIT    = 1,
   parameter logic [AW-1:0] WP_BASE = 8'hC0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sel,
   input  logic          wr_n,
   input  logic [AW-1:0] a,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          rdy,
   output logic          wp_err
);

   localparam int         DEPTH    = 1 << AW;
   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   logic [1:0]    state_reg;
   logic [3:0]    cnt_reg;
   logic [AW-1:0] a_reg;
   logic [DW-1:0] din_reg;
   logic          wr_n_reg;
   logic [DW-1:0] dout_reg;
   logic          rdy_reg;
   logic          wp_err_reg;

   // The power-up image puts all ones in word 0 and zeros everywhere else.
   // Reset never touches the array.
   logic [DW-1:0] mem_reg [0:DEPTH-1] = '{0: {DW{1'b1}}, default: {DW{1'b0}}};

   logic access;
   logic wp_hit;
   logic mem_we;

   // The access happens on the BUSY edge where the counter has already reached
   // zero. That makes the total latency WAIT+1 edges after acceptance.
   assign access = (state_reg == ST_BUSY) && (cnt_reg == 4'd0);

`ifdef MEM_RAM_WP_EN
   assign wp_hit = !wr_n_reg && (a_reg >= WP_BASE);
`else
   logic unused_wp_base;
   assign wp_hit         = 1'b0;
   assign unused_wp_base = ^WP_BASE;
`endif

   assign mem_we = access && !wr_n_reg && !wp_hit;

   // The array write port has no reset, so that it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_reg[a_reg] <= din_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= 4'd0;
         a_reg      <= '0;
         din_reg    <= '0;
         wr_n_reg   <= 1'b1;
         dout_reg   <= '0;
         rdy_reg    <= 1'b0;
         wp_err_reg <= 1'b0;
      end else begin
         rdy_reg    <= 1'b0;
         wp_err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (sel) begin
                  a_reg     <= a;
                  din_reg   <= din;
                  wr_n_reg  <= wr_n;
                  cnt_reg   <= WAIT_CNT;
                  state_reg <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Inputs are ignored in this state. A pending access always
               // completes, even if sel drops.
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  state_reg  <= ST_ACK;
                  rdy_reg    <= 1'b1;
                  wp_err_reg <= wp_hit;
                  // dout is updated only by reads. Writes leave the last
                  // read value visible.
                  if (wr_n_reg) begin
                     dout_reg <= mem_reg[a_reg];
                  end
               end
            end
            ST_ACK: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign dout   = dout_reg;
   assign rdy    = rdy_reg;
   assign wp_err = wp_err_reg;

endmodule
